// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: requester beat channels, vram write port and status of the framebuffer write arbiter.
interface fb_write_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 24
);
  logic              r0_valid, r0_ready, r0_last;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_data;
  logic              r1_valid, r1_ready, r1_last;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_waddr;
  logic [DATA_W-1:0] fb_wdata;
  logic [1:0]        gnt;
  logic              err_oob, err_clr;
  modport slave (
    input  r0_valid, r0_addr, r0_data, r0_last, r1_valid, r1_addr, r1_data, r1_last, err_clr,
    output r0_ready, r1_ready, fb_we, fb_waddr, fb_wdata, gnt, err_oob
  );
  modport master (
    output r0_valid, r0_addr, r0_data, r0_last, r1_valid, r1_addr, r1_data, r1_last, err_clr,
    input  r0_ready, r1_ready, fb_we, fb_waddr, fb_wdata, gnt, err_oob
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin burst arbiter sharing the vram write port between CPU (r0) and DMA (r1).
module fb_write_arbiter #(
  parameter int unsigned WIDTH        = 1280,
  parameter int unsigned HEIGHT       = 720,
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input logic clk,
  input logic rst,
  fb_write_arbiter_if.slave bus
);
  localparam int unsigned BW  = $clog2(MAX_BURST + 1);
  localparam int unsigned IW  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned PIX = WIDTH * HEIGHT;
  localparam logic [BW-1:0] BEAT_END = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_END = IW'(IDLE_TIMEOUT - 1);
  // Encoding doubles as the one-hot gnt output.
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  state_t            state_q, state_d;
  logic              last_gnt_q, fb_we_q, err_q;
  logic [BW-1:0]     beat_cnt_q;
  logic [IW-1:0]     idle_cnt_q;
  logic [ADDR_W-1:0] waddr_q, addr;
  logic [DATA_W-1:0] wdata_q, data;
  logic              sel1, granted, valid, last, acc, in_range, release_g, other_valid, entry;
  always_comb begin
    sel1        = state_q == GNT1;
    granted     = state_q != IDLE;
    valid       = sel1 ? bus.r1_valid : bus.r0_valid;
    last        = sel1 ? bus.r1_last : bus.r0_last;
    addr        = sel1 ? bus.r1_addr : bus.r0_addr;
    data        = sel1 ? bus.r1_data : bus.r0_data;
    other_valid = sel1 ? bus.r0_valid : bus.r1_valid;
    acc         = granted && valid;
    in_range    = 32'(addr) < PIX;
    release_g   = acc ? (last || beat_cnt_q == BEAT_END) : (granted && idle_cnt_q == IDLE_END);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (bus.r0_valid && bus.r1_valid) ? (last_gnt_q ? GNT0 : GNT1) :
                bus.r0_valid ? GNT0 : bus.r1_valid ? GNT1 : IDLE;
    else if (release_g)
      state_d = other_valid ? (sel1 ? GNT0 : GNT1) : IDLE;
  end
  always_comb begin
    bus.r0_ready = state_q == GNT0;
    bus.r1_ready = state_q == GNT1;
    bus.gnt      = state_q;
    bus.fb_we    = fb_we_q;
    bus.fb_waddr = waddr_q;
    bus.fb_wdata = wdata_q;
    bus.err_oob  = err_q;
  end
  assign entry = state_d != IDLE && state_d != state_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_gnt_q <= 1'b1;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      fb_we_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      last_gnt_q <= entry ? state_d == GNT1 : last_gnt_q;
      beat_cnt_q <= entry ? '0 : acc ? beat_cnt_q + 1'b1 : beat_cnt_q;
      idle_cnt_q <= (entry || acc) ? '0 : granted ? idle_cnt_q + 1'b1 : idle_cnt_q;
      fb_we_q    <= acc && in_range;
      waddr_q    <= acc ? addr : waddr_q;
      wdata_q    <= acc ? data : wdata_q;
      // A new out-of-range beat wins over a simultaneous clear.
      err_q      <= (acc && !in_range) || (err_q && !bus.err_clr);
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed stimulus with a write scoreboard drained by an independent vram-port monitor.
module tb_fb_write_arbiter;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0, n_fail = 0, n_wr = 0, cyc = 0, first_wr = 0, last_wr = 0;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;
  fb_write_arbiter_if #(.ADDR_W(20), .DATA_W(24)) bus();
  fb_write_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.fb_we === 1'b1) begin
      n_wr++;
      if (n_wr == 1) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got %0h/%0h expected no write", bus.fb_waddr, bus.fb_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr", {bus.fb_waddr, bus.fb_wdata}, mon_e);
      end
    end
  task automatic expw(input logic [19:0] a, input logic [23:0] d);
    exp_q.push_back({a, d});
  endtask
  task automatic send(input int r, input logic [19:0] a, input logic [23:0] d, input logic l);
    bit acc = 0;
    if (r == 0) begin
      bus.r0_valid = 1; bus.r0_addr = a; bus.r0_data = d; bus.r0_last = l;
    end else begin
      bus.r1_valid = 1; bus.r1_addr = a; bus.r1_data = d; bus.r1_last = l;
    end
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = (r == 0) ? bus.r0_ready : bus.r1_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout r%0d: got no ready expected ready within 100 cycles", r);
    end
  endtask
  task automatic settle(input string nm, input int exp_wr, input int exp_span);
    repeat (12) @(posedge clk);
    #1;
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 0);
    chk({nm, "_nwr"}, 64'(n_wr), 64'(exp_wr));
    if (exp_span >= 0) chk({nm, "_span"}, 64'(last_wr - first_wr), 64'(exp_span));
    exp_q.delete();
    n_wr = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    {bus.r0_valid, bus.r0_last, bus.r1_valid, bus.r1_last, bus.err_clr} = '0;
    bus.r0_addr = '0; bus.r0_data = '0; bus.r1_addr = '0; bus.r1_data = '0;
    #2 rst = 0;
    #1;
    chk("rst_gnt", 64'(bus.gnt), 0);
    chk("rst_we", 64'(bus.fb_we), 0);
    chk("rst_waddr", 64'(bus.fb_waddr), 0);
    chk("rst_wdata", 64'(bus.fb_wdata), 0);
    chk("rst_err", 64'(bus.err_oob), 0);
    chk("rst_ready", 64'({bus.r0_ready, bus.r1_ready}), 0);
    do_reset();
    // 4-beat r0 burst
    for (int i = 0; i < 4; i++) expw(20'(i), 24'h0000FF);
    bus.r0_valid = 1; bus.r0_addr = 0; bus.r0_data = 24'h0000FF; bus.r0_last = 0;
    @(negedge clk);
    chk("t1_ready_latency", 64'(bus.r0_ready), 0);
    for (int i = 0; i < 4; i++) send(0, 20'(i), 24'h0000FF, i == 3);
    bus.r0_valid = 0;
    chk("t1_gnt_idle", 64'(bus.gnt), 0);
    settle("t1", 4, 3);
    // alternating 2-beat bursts, zero-bubble handoff
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 2; i++) expw(20'(10 + 2*b + i), 24'(32'hA20000 + 2*b + i));
      for (int i = 0; i < 2; i++) expw(20'(20 + 2*b + i), 24'(32'h0B2000 + 2*b + i));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 20'(10 + i), 24'(32'hA20000 + i), i[0]);
        bus.r0_valid = 0;
      end
      begin
        for (int j = 0; j < 4; j++) send(1, 20'(20 + j), 24'(32'h0B2000 + j), j[0]);
        bus.r1_valid = 0;
      end
    join
    settle("t2", 8, 7);
    // 40-beat r1 stream capped at 16 beats per grant
    for (int i = 0; i < 40; i++) expw(20'(1000 + i), 24'(32'h00B100 + i));
    for (int i = 0; i < 40; i++) send(1, 20'(1000 + i), 24'(32'h00B100 + i), 1'b0);
    bus.r1_valid = 0;
    settle("t3", 40, 41);
    // idle timeout hands r0's grant to r1
    expw(20'd100, 24'hA10000);
    expw(20'd200, 24'h00B200);
    send(0, 20'd100, 24'hA10000, 1'b0);
    bus.r0_valid = 0;
    bus.r1_valid = 1; bus.r1_addr = 20'd200; bus.r1_data = 24'h00B200; bus.r1_last = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) chk("t4_gnt_hold", 64'(bus.gnt), 64'h1);
      if (k == 8) chk("t4_gnt_switch", 64'(bus.gnt), 64'h2);
    end
    send(1, 20'd200, 24'h00B200, 1'b1);
    bus.r1_valid = 0;
    settle("t4", 2, -1);
    // out-of-range beats and sticky error flag
    chk("t5_err_init", 64'(bus.err_oob), 0);
    expw(20'd5, 24'h0000AA);
    send(0, 20'd921600, 24'h123456, 1'b0);
    chk("t5_oob_we", 64'(bus.fb_we), 0);
    chk("t5_oob_err", 64'(bus.err_oob), 1);
    send(0, 20'd5, 24'h0000AA, 1'b1);
    bus.r0_valid = 0;
    chk("t5_err_sticky", 64'(bus.err_oob), 1);
    bus.err_clr = 1;
    @(posedge clk);
    #1;
    bus.err_clr = 0;
    chk("t5_err_clr", 64'(bus.err_oob), 0);
    bus.err_clr = 1;
    send(0, 20'd1000000, 24'h000077, 1'b1);
    bus.r0_valid = 0;
    chk("t5_set_wins", 64'(bus.err_oob), 1);
    bus.err_clr = 0;
    settle("t5", 1, -1);
    // asynchronous reset mid-burst
    expw(20'd300, 24'h0000C0);
    expw(20'd301, 24'h0000C1);
    send(0, 20'd300, 24'h0000C0, 1'b0);
    send(0, 20'd301, 24'h0000C1, 1'b0);
    @(negedge clk);
    #1;
    chk("t6_we_before", 64'(bus.fb_we), 1);
    rst = 0;
    #1;
    chk("t6_async_we", 64'(bus.fb_we), 0);
    chk("t6_async_gnt", 64'(bus.gnt), 0);
    bus.r0_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("t6_err_reset", 64'(bus.err_oob), 0);
    chk("t6_waddr_reset", 64'(bus.fb_waddr), 0);
    expw(20'd400, 24'h0000D0);
    expw(20'd500, 24'h0000E0);
    fork
      begin send(0, 20'd400, 24'h0000D0, 1'b1); bus.r0_valid = 0; end
      begin send(1, 20'd500, 24'h0000E0, 1'b1); bus.r1_valid = 0; end
    join
    settle("t6", 4, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single framebuffer (vram) write port between two requesters: requester 0 (CPU store path) and requester 1 (fill/blit DMA).
- Arbitration is round-robin with burst locking, a burst-length cap and an idle-release timeout.
- Drives the vram write enable, address and data as registered outputs in the pixel-write clock domain.
- Flags and suppresses out-of-range addresses.

Parameters:
- WIDTH, 1280, active pixels per line.
- HEIGHT, 720, active lines.
- ADDR_W, 20, framebuffer address width (clog2(WIDTH*HEIGHT)).
- DATA_W, 24, pixel width as {R[23:16], G[15:8], B[7:0]}.
- MAX_BURST, 16, maximum accepted beats per grant (≥1).
- IDLE_TIMEOUT, 8, consecutive granted cycles without r*_valid before the grant is released (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 beat valid.
- r0_ready  out  1  requester 0 beat accepted when valid&&ready.
- r0_addr  in  ADDR_W  requester 0 pixel address.
- r0_data  in  DATA_W  requester 0 pixel data.
- r0_last  in  1  requester 0 final beat of burst.
- r1_valid, r1_ready, r1_addr, r1_data, r1_last: same as requester 0, for requester 1.
- fb_we  out  1  vram write enable.
- fb_waddr  out  ADDR_W  vram write address.
- fb_wdata  out  DATA_W  vram write data.
- gnt  out  2  one-hot current grant; 2'b00 when idle.
- err_oob  out  1  sticky out-of-range write flag.
- err_clr  in  1  clears err_oob.

Behaviour:
- States: IDLE, GNT0, GNT1. rN_ready = (state==GNTN), decoded from state only; no combinational path from valid to ready.
- Reset (rst=0, async): state=IDLE, last_gnt=1, beat_cnt=0, idle_cnt=0, fb_we=0, fb_waddr=0, fb_wdata=0, err_oob=0. Consequence: requester 0 wins the first arbitration.
- IDLE:
  - If exactly one valid, go to that requester's GNT state.
  - If both valid, grant the requester != last_gnt.
  - If none valid, stay in IDLE.
  - The transition costs one cycle; ready first asserts the cycle after valid is seen in IDLE.
- On entry to GNTN: beat_cnt=0, idle_cnt=0, last_gnt=N.
- GNTN, accepted beat (rN_valid && rN_ready):
  - beat_cnt increments and idle_cnt clears.
  - End of grant when rN_last=1 or beat_cnt==MAX_BURST-1.
  - At end of grant: if the other requester is valid that cycle, move directly to GNT(other) with zero bubble; otherwise go to IDLE.
  - Never re-grant the same requester without passing through IDLE.
- GNTN, rN_valid=0:
  - idle_cnt increments; beat_cnt holds.
  - When idle_cnt reaches IDLE_TIMEOUT-1, release the grant using the same handoff rule.
  - A partially complete burst is simply abandoned; no error is raised.
- Write path, latency 1:
  - fb_we <= accepted && (addr < WIDTH*HEIGHT).
  - fb_waddr and fb_wdata <= the granted requester's addr/data when a beat is accepted; otherwise they hold their values.
  - fb_we=0 on every cycle with no accepted in-range beat.
- Out-of-range:
  - A beat with addr ≥ WIDTH*HEIGHT is still accepted (ready is unaffected) and counts toward beat_cnt.
  - No write is issued; err_oob is set on the next cycle.
  - err_clr clears err_oob. If err_clr and a new OOB beat occur in the same cycle, set wins.
- gnt mirrors the state: 2'b01 = GNT0, 2'b10 = GNT1, 2'b00 = IDLE.
- A requester may change addr/data only after an accepted beat or while valid=0. Holding valid until accepted is the requester's responsibility; the arbiter does not check it.
- Reset mid-burst: immediate return to the reset state; any in-flight fb_we drops asynchronously.

Test Plan:
- Reset release, r0 sends a 4-beat burst (addr 0..3, data 0x0000FF, last on beat 4) -> r0_ready rises 1 cycle after valid; fb_we high 4 cycles, waddr 0..3 at 1-cycle lag; gnt returns to 00.
- Both requesters valid continuously with 2-beat bursts -> grant order 0,1,0,1, direct handoff with no IDLE cycle between bursts; no beat lost.
- r1 streams 40 beats with last never asserted, MAX_BURST=16, r0 idle -> grant released after beats 16 and 32 via IDLE, re-granted to r1; all 40 writes issued.
- r0 granted and then drops valid for 8 cycles while r1 is valid -> gnt switches to 10 exactly after the 8th idle cycle.
- r0 writes addr 921600 then addr 5 -> 921600 accepted with fb_we=0 and err_oob=1; addr 5 written. err_clr=1 -> err_oob=0 next cycle. Concurrent err_clr with a new OOB beat -> err_oob stays 1.
- Assert rst mid-burst -> fb_we=0 and gnt=00 asynchronously. After release, both requesters valid -> r0 is granted first.
